// File: rtl/fetch_sequencer.sv
// Fetch-stage control: PC enable/select, IMEM request handshake, redirect and load-use handling.
// Optional performance counters are compiled in when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer #(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64
`ifdef FETCH_SEQ_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REDIRECT_VALID,
  input  logic [1:0] REDIRECT_SRC,
  input  logic       LOAD_USE_STALL,
  input  logic       IMEM_READY,
  output logic       IMEM_REQ,
  output logic       PC_RESET,
  output logic       PC_WRITE,
  output logic [1:0] PC_SOURCE,
  output logic       IF_ID_WRITE,
  output logic       IF_ID_FLUSH,
  output logic       ID_EX_FLUSH,
  output logic       FETCH_ERR
`ifdef FETCH_SEQ_PERF_EN
  , output logic [CNT_W-1:0] FETCH_CNT,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] REDIR_CNT
`endif
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    REDIR_PEND = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [BOOT_W-1:0]   boot_cnt_reg, boot_cnt_next;
  logic [1:0]          pend_src_reg, pend_src_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic                pc_reset_reg, fetch_err_reg, fetch_err_next;
  logic                redirect;

  // A redirect with source 00 is not a real redirect.
  assign redirect  = REDIRECT_VALID && (REDIRECT_SRC != 2'b00);
  assign PC_RESET  = pc_reset_reg;
  assign FETCH_ERR = fetch_err_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= BOOT;
      boot_cnt_reg  <= '0;
      pend_src_reg  <= 2'b00;
      wait_cnt_reg  <= '0;
      pc_reset_reg  <= 1'b1;
      fetch_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      boot_cnt_reg  <= boot_cnt_next;
      pend_src_reg  <= pend_src_next;
      wait_cnt_reg  <= wait_cnt_next;
      pc_reset_reg  <= (state_next == BOOT);
      fetch_err_reg <= fetch_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    boot_cnt_next = boot_cnt_reg;
    pend_src_next = pend_src_reg;
    IMEM_REQ      = 1'b0;
    PC_WRITE      = 1'b0;
    PC_SOURCE     = 2'b00;
    IF_ID_WRITE   = 1'b1;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_FLUSH   = 1'b0;

    unique case (state_reg)
      BOOT: begin
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
        if (boot_cnt_reg == BOOT_W'(BOOT_CYCLES - 1)) begin
          state_next = RUN;
        end else begin
          boot_cnt_next = boot_cnt_reg + 1'b1;
        end
      end
      RUN: begin
        IMEM_REQ = 1'b1;
        if (redirect) begin
          IF_ID_FLUSH = 1'b1;
          ID_EX_FLUSH = 1'b1;
          if (IMEM_READY) begin
            PC_WRITE  = 1'b1;
            PC_SOURCE = REDIRECT_SRC;
          end else begin
            // The request at the old PC is still in flight, so the PC must hold.
            pend_src_next = REDIRECT_SRC;
            state_next    = REDIR_PEND;
          end
        end else if (LOAD_USE_STALL) begin
          IF_ID_WRITE = 1'b0;
          ID_EX_FLUSH = 1'b1;
        end else if (!IMEM_READY) begin
          IF_ID_FLUSH = 1'b1;
        end else begin
          PC_WRITE = 1'b1;
        end
      end
      REDIR_PEND: begin
        IMEM_REQ    = 1'b1;
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
        if (redirect) begin
          pend_src_next = REDIRECT_SRC;
        end
        if (IMEM_READY) begin
          PC_WRITE      = 1'b1;
          PC_SOURCE     = redirect ? REDIRECT_SRC : pend_src_reg;
          pend_src_next = 2'b00;
          state_next    = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // Watchdog: saturates at MEM_TIMEOUT, error flag is sticky until reset.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if ((state_reg == BOOT) || IMEM_READY) begin
      wait_cnt_next = '0;
    end else if (IMEM_REQ && (wait_cnt_reg != WAIT_W'(MEM_TIMEOUT))) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
    fetch_err_next = fetch_err_reg || (wait_cnt_next == WAIT_W'(MEM_TIMEOUT));
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [2:0]       perf_inc;
  logic [CNT_W-1:0] perf_cnt_reg [3];

  assign perf_inc[0] = PC_WRITE && (PC_SOURCE == 2'b00);
  assign perf_inc[1] = (state_reg != BOOT) && !PC_WRITE;
  assign perf_inc[2] = PC_WRITE && (PC_SOURCE != 2'b00);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      always_ff @(posedge CLK) begin
        if (RESET) begin
          perf_cnt_reg[gi] <= '0;
        end else if (perf_inc[gi] && (perf_cnt_reg[gi] != '1)) begin
          perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign FETCH_CNT = perf_cnt_reg[0];
  assign STALL_CNT = perf_cnt_reg[1];
  assign REDIR_CNT = perf_cnt_reg[2];
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected outputs, a negedge monitor compares.
module tb_fetch_sequencer;

  logic       CLK;
  logic       RESET;
  logic       REDIRECT_VALID;
  logic [1:0] REDIRECT_SRC;
  logic       LOAD_USE_STALL;
  logic       IMEM_READY;
  logic       IMEM_REQ, PC_RESET, PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, FETCH_ERR;
  logic [1:0] PC_SOURCE;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] FETCH_CNT, STALL_CNT, REDIR_CNT;
`endif

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q [$];
  string      name_q [$];

  fetch_sequencer #(
    .BOOT_CYCLES(2),
    .MEM_TIMEOUT(4)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .REDIRECT_VALID(REDIRECT_VALID),
    .REDIRECT_SRC(REDIRECT_SRC),
    .LOAD_USE_STALL(LOAD_USE_STALL),
    .IMEM_READY(IMEM_READY),
    .IMEM_REQ(IMEM_REQ),
    .PC_RESET(PC_RESET),
    .PC_WRITE(PC_WRITE),
    .PC_SOURCE(PC_SOURCE),
    .IF_ID_WRITE(IF_ID_WRITE),
    .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_FLUSH(ID_EX_FLUSH),
    .FETCH_ERR(FETCH_ERR)
`ifdef FETCH_SEQ_PERF_EN
    , .FETCH_CNT(FETCH_CNT),
    .STALL_CNT(STALL_CNT),
    .REDIR_CNT(REDIR_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output vector order: {req, pc_reset, pc_write, pc_source[1:0], if_id_write, if_id_flush, id_ex_flush, fetch_err}
  function automatic logic [8:0] e(input logic req, prst, pw, input logic [1:0] ps,
                                   input logic ifw, ifl, idf, err);
    return {req, prst, pw, ps, ifw, ifl, idf, err};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, req);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [8:0] ex;
      string      nm;
      ex = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, 64'({IMEM_REQ, PC_RESET, PC_WRITE, PC_SOURCE, IF_ID_WRITE,
                     IF_ID_FLUSH, ID_EX_FLUSH, FETCH_ERR}), 64'(ex));
    end
  end

  task automatic step(input string nm, input logic rst, rv, input logic [1:0] src,
                      input logic lus, rdy, chk, input logic [8:0] ex);
    RESET          = rst;
    REDIRECT_VALID = rv;
    REDIRECT_SRC   = src;
    LOAD_USE_STALL = lus;
    IMEM_READY     = rdy;
    if (chk) begin
      exp_q.push_back(ex);
      name_q.push_back(nm);
    end
    @(posedge CLK);
    #1;
  endtask

  localparam logic [1:0] S00 = 2'b00, S01 = 2'b01, S10 = 2'b10, S11 = 2'b11;

  initial begin
    logic [8:0] boot_o, norm_o, pend_o, lu_o, wait_o, wait_err;
    boot_o   = e(0, 1, 0, S00, 1, 1, 1, 0);
    norm_o   = e(1, 0, 1, S00, 1, 0, 0, 0);
    pend_o   = e(1, 0, 0, S00, 1, 1, 1, 0);
    lu_o     = e(1, 0, 0, S00, 0, 0, 1, 0);
    wait_o   = e(1, 0, 0, S00, 1, 1, 0, 0);
    wait_err = e(1, 0, 0, S00, 1, 1, 0, 1);

    // Boot sequence: three reset cycles, then two boot cycles after release.
    step("rst0",        1, 0, S00, 0, 1, 0, '0);
    step("rst1",        1, 0, S00, 0, 1, 1, boot_o);
    step("rst2",        1, 0, S00, 0, 1, 1, boot_o);
    step("boot1",       0, 0, S00, 0, 1, 1, boot_o);
    step("boot2",       0, 0, S00, 0, 1, 1, boot_o);
    step("run_first",   0, 0, S00, 0, 1, 1, norm_o);
    step("run_norm",    0, 0, S00, 0, 1, 1, norm_o);
    // Redirect with memory ready: applied immediately.
    step("redir_jal",   0, 1, S11, 0, 1, 1, e(1, 0, 1, S11, 1, 1, 1, 0));
    step("after_jal",   0, 0, S00, 0, 1, 1, norm_o);
    // Redirect while memory busy: held until the word returns.
    step("busy_jalr",   0, 1, S01, 0, 0, 1, pend_o);
    step("pend_w1",     0, 0, S00, 0, 0, 1, pend_o);
    step("pend_w2",     0, 0, S00, 0, 0, 1, pend_o);
    step("pend_done",   0, 0, S00, 0, 1, 1, e(1, 0, 1, S01, 1, 1, 1, 0));
    step("after_pend",  0, 0, S00, 0, 1, 1, norm_o);
    // Newest pending redirect wins; load-use ignored while pending.
    step("busy_br",     0, 1, S10, 0, 0, 1, pend_o);
    step("pend_ovr",    0, 1, S11, 1, 0, 1, pend_o);
    step("pend_newest", 0, 0, S00, 0, 1, 1, e(1, 0, 1, S11, 1, 1, 1, 0));
    step("busy_jalr2",  0, 1, S01, 0, 0, 1, pend_o);
    step("pend_samecy", 0, 1, S10, 0, 1, 1, e(1, 0, 1, S10, 1, 1, 1, 0));
    step("src00_ign",   0, 1, S00, 0, 1, 1, norm_o);
    // Load-use, then memory wait bubbles.
    step("load_use",    0, 0, S00, 1, 1, 1, lu_o);
    step("memwait1",    0, 0, S00, 0, 0, 1, wait_o);
    step("memwait2",    0, 0, S00, 0, 0, 1, wait_o);
    step("resume",      0, 0, S00, 0, 1, 1, norm_o);
    step("redir_gt_lu", 0, 1, S10, 1, 1, 1, e(1, 0, 1, S10, 1, 1, 1, 0));
    // Timeout: flag visible after the 4th consecutive wait cycle, sticky afterwards.
    step("to_w1",       0, 0, S00, 0, 0, 1, wait_o);
    step("to_w2",       0, 0, S00, 0, 0, 1, wait_o);
    step("to_w3",       0, 0, S00, 0, 0, 1, wait_o);
    step("to_w4",       0, 0, S00, 0, 0, 1, wait_o);
    step("to_w5_err",   0, 0, S00, 0, 0, 1, wait_err);
    step("err_sticky1", 0, 0, S00, 0, 1, 1, e(1, 0, 1, S00, 1, 0, 0, 1));
    step("err_sticky2", 0, 0, S00, 0, 1, 1, e(1, 0, 1, S00, 1, 0, 0, 1));
    // Reset beats a pending redirect and clears the error flag.
    step("busy_pre_rst",0, 1, S11, 0, 0, 1, e(1, 0, 0, S00, 1, 1, 1, 1));
    step("rst_in_pend", 1, 0, S00, 0, 0, 1, e(1, 0, 0, S00, 1, 1, 1, 1));
    step("reboot1",     0, 0, S00, 0, 1, 1, boot_o);
    step("reboot2",     0, 0, S00, 0, 1, 1, boot_o);
    step("run_no_pend", 0, 0, S00, 0, 1, 1, norm_o);

`ifdef FETCH_SEQ_PERF_EN
    step("perf_rst",    1, 0, S00, 0, 1, 1, norm_o);
    step("perf_boot1",  0, 0, S00, 0, 1, 1, boot_o);
    step("perf_boot2",  0, 0, S00, 0, 1, 1, boot_o);
    for (int i = 0; i < 10; i++) begin
      step("perf_fetch", 0, 0, S00, 0, 1, 1, norm_o);
    end
    step("perf_redir",  0, 1, S10, 0, 1, 1, e(1, 0, 1, S10, 1, 1, 1, 0));
    for (int i = 0; i < 3; i++) begin
      step("perf_stall", 0, 0, S00, 0, 0, 1, wait_o);
    end
    check("fetch_cnt", 64'(FETCH_CNT), 64'd10);
    check("redir_cnt", 64'(REDIR_CNT), 64'd1);
    check("stall_cnt", 64'(STALL_CNT), 64'd3);
`endif

    step("idle", 0, 0, S00, 0, 1, 0, '0);
    repeat (2) @(posedge CLK);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control block for the pipeline fetch stage. Each cycle it generates PC_WRITE, PC_SOURCE and PC_RESET for the program counter.
- Sequences instruction-memory requests with a request/ready handshake.
- Applies redirects (JALR, BRANCH, JAL) resolved in EX, including redirects that arrive while a fetch is still outstanding.
- Drives the IF/ID write and flush controls and the ID/EX flush for load-use stalls and redirects.

Parameters:
- BOOT_CYCLES, 2, cycles PC_RESET stays asserted after RESET deasserts (min 1).
- MEM_TIMEOUT, 64, consecutive IMEM_READY-low cycles in one fetch before FETCH_ERR sets (min 2).
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- CLK  in  1  pipeline clock, posedge.
- RESET  in  1  synchronous, active-high.
- REDIRECT_VALID  in  1  EX resolved a taken branch or jump this cycle.
- REDIRECT_SRC  in  2  01 JALR, 10 BRANCH, 11 JAL; 00 with REDIRECT_VALID=1 is ignored.
- LOAD_USE_STALL  in  1  decode detected a load-use hazard.
- IMEM_READY  in  1  instruction memory returns the word for the current PC this cycle.
- IMEM_REQ  out  1  fetch request at the current PC.
- PC_RESET  out  1  to the PC register.
- PC_WRITE  out  1  PC register enable.
- PC_SOURCE  out  2  PC mux select: 00 PC+4, 01 JALR, 10 BRANCH, 11 JAL.
- IF_ID_WRITE  out  1  IF/ID register enable.
- IF_ID_FLUSH  out  1  load a bubble into IF/ID.
- ID_EX_FLUSH  out  1  load a bubble into ID/EX.
- FETCH_ERR  out  1  sticky memory timeout flag.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high: RESET is sampled on the CLK posedge. Port names are CLK and RESET.
- RESET=1 forces the following on the next edge:
  - state=BOOT, boot counter=0, pend_src=00, wait counter=0.
  - FETCH_ERR=0, counters=0.
- Output values while in BOOT:
  - PC_RESET=1, PC_WRITE=0, PC_SOURCE=00, IMEM_REQ=0.
  - IF_ID_WRITE=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1.
- Registered vs combinational outputs:
  - PC_RESET and FETCH_ERR are registered.
  - All other outputs are combinational from state and current inputs (zero-cycle latency).
- States: BOOT, RUN, REDIR_PEND.
- BOOT: counts cycles with RESET=0. After BOOT_CYCLES such cycles, go to RUN; PC_RESET deasserts on that edge.
- RUN: IMEM_REQ=1. Priority is redirect > load-use > memory wait.
  - Redirect with IMEM_READY=1:
    - PC_WRITE=1, PC_SOURCE=REDIRECT_SRC.
    - IF_ID_FLUSH=1, ID_EX_FLUSH=1.
    - Stay in RUN.
  - Redirect with IMEM_READY=0:
    - PC_WRITE=0; PC is held because the request is in flight.
    - pend_src<=REDIRECT_SRC.
    - IF_ID_FLUSH=1, ID_EX_FLUSH=1.
    - Go to REDIR_PEND.
  - Load-use (no redirect): PC_WRITE=0, IF_ID_WRITE=0, IF_ID_FLUSH=0, ID_EX_FLUSH=1. Any returned word is dropped and refetched.
  - IMEM_READY=0 (no redirect, no stall): PC_WRITE=0, IF_ID_WRITE=1, IF_ID_FLUSH=1 (bubble into decode).
  - Otherwise: PC_WRITE=1, PC_SOURCE=00, IF_ID_WRITE=1, no flushes.
- REDIR_PEND:
  - Each cycle: IMEM_REQ=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, LOAD_USE_STALL ignored.
  - A new valid REDIRECT overwrites pend_src (newest wins).
  - On IMEM_READY=1: PC_WRITE=1, PC_SOURCE=pend_src (or the same-cycle REDIRECT_SRC if valid). The returned word is discarded via flush. Go to RUN.
- Timeout watchdog:
  - Wait counter increments each cycle IMEM_REQ=1 and IMEM_READY=0. It clears on IMEM_READY=1 or in BOOT.
  - Reaching MEM_TIMEOUT sets FETCH_ERR, which is sticky until RESET.
  - FETCH_ERR does not alter sequencing. The counter saturates.
- Defaults in all states: IF_ID_WRITE=1 unless stated otherwise; the PC_SOURCE default is 00.
- RESET mid-operation wins over everything, including pending redirects.

Optional Feature:
- Macro FETCH_SEQ_PERF_EN.
- When defined, three extra outputs exist, each CNT_W wide and saturating at all-ones:
  - FETCH_CNT: counts cycles with PC_WRITE=1 and PC_SOURCE=00.
  - STALL_CNT: counts cycles in RUN or REDIR_PEND with PC_WRITE=0.
  - REDIR_CNT: counts cycles where a redirect is applied (PC_WRITE=1 and PC_SOURCE!=00).
- All three counters clear on RESET.
- When undefined, these ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Boot: RESET=1 for 3 cycles then 0, IMEM_READY=1 -> PC_RESET=1 through the 2nd cycle after release; PC_WRITE=1, PC_SOURCE=00 from the 3rd cycle.
- Redirect, memory ready: in RUN, REDIRECT_VALID=1, SRC=11, IMEM_READY=1 -> same cycle PC_WRITE=1, PC_SOURCE=11, both flushes=1; next cycle PC_SOURCE=00.
- Redirect, memory busy: REDIRECT_VALID=1, SRC=01, IMEM_READY=0 for 3 cycles then 1 -> PC_WRITE=0 for 3 cycles with flushes=1; 4th cycle PC_WRITE=1, PC_SOURCE=01; then RUN.
- Load-use plus wait: LOAD_USE_STALL=1 one cycle -> PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1. Then IMEM_READY=0 for 2 cycles -> IF_ID_FLUSH=1, PC_WRITE=0.
- Timeout: MEM_TIMEOUT=4, IMEM_READY=0 for 5 cycles -> FETCH_ERR=1 after the 4th and stays 1 after IMEM_READY returns; clears only on RESET.
- Perf (FETCH_SEQ_PERF_EN): 10 normal fetches, 1 redirect, 3 stall cycles -> FETCH_CNT=10, REDIR_CNT=1, STALL_CNT=3.
